// File: rtl/vector_alu.sv
// Two-stage SIMD ALU: LANES independent WIDTH-bit lanes sharing one opcode.
// S1 registers the operation, S2 registers per-lane results and flags behind a valid/ready handshake.
module vector_alu #(
    parameter int LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [3:0]             in_op,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_zero,
    output logic [LANES-1:0]       out_neg,
    output logic [LANES-1:0]       out_carry,
    output logic                   out_err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_LSL = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_SET = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ROL = 4'd9;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             n;
        logic             c;
    } lane_t;

    // One lane of the datapath; reserved opcodes yield zero result and flags regardless of mask.
    function automatic lane_t lane_op(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [3:0]       op,
                                      input logic             en);
        lane_t            r;
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   dif;
        logic [WIDTH-1:0] src;
        logic [SHW-1:0]   amt;
        logic [SHW-1:0]   amt_n;
        r     = '0;
        amt   = b[SHW-1:0];
        amt_n = -amt;
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        case (op)
            OP_ADD: begin r.res = sum[WIDTH-1:0]; r.c = sum[WIDTH];  end
            OP_SUB: begin r.res = dif[WIDTH-1:0]; r.c = ~dif[WIDTH]; end
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_LSL: r.res = a << amt;
            OP_CMP: begin r.res = a; r.c = ~dif[WIDTH]; end
            OP_SET: r.res = b;
            OP_XOR: r.res = a ^ b;
            OP_LSR: r.res = a >> amt;
            // amt_n is (WIDTH - amt) mod WIDTH, so amt == 0 degenerates to a | a
            OP_ROL: r.res = (a << amt) | (a >> amt_n);
            default: r.res = '0;
        endcase
        src = (op == OP_CMP) ? dif[WIDTH-1:0] : r.res;
        if (op <= OP_ROL) begin
            r.z = (src == '0);
            r.n = src[WIDTH-1];
            if (!en) begin
                r.res = a;
                r.z   = 1'b0;
                r.n   = 1'b0;
                r.c   = 1'b0;
            end
        end
        return r;
    endfunction

    logic                   vld_p1_q, vld_p1_d;
    logic [LANES*WIDTH-1:0] a_p1_q, a_p1_d;
    logic [LANES*WIDTH-1:0] b_p1_q, b_p1_d;
    logic [3:0]             op_p1_q, op_p1_d;
    logic [LANES-1:0]       mask_p1_q, mask_p1_d;

    logic                   vld_p2_q, vld_p2_d;
    logic [LANES*WIDTH-1:0] data_p2_q, data_p2_d;
    logic [LANES-1:0]       zero_p2_q, zero_p2_d;
    logic [LANES-1:0]       neg_p2_q, neg_p2_d;
    logic [LANES-1:0]       carry_p2_q, carry_p2_d;
    logic                   err_p2_q, err_p2_d;

    logic  adv_p2;
    logic  load_p1;
    logic  load_p2;
    lane_t lr;

    assign adv_p2   = !vld_p2_q || out_ready;
    assign in_ready = !vld_p1_q || !vld_p2_q || out_ready;
    assign load_p1  = in_valid && in_ready;
    assign load_p2  = adv_p2 && vld_p1_q;

    // Stage 1: capture the accepted operation
    always_comb begin
        vld_p1_d  = in_ready ? in_valid : vld_p1_q;
        a_p1_d    = load_p1 ? in_a    : a_p1_q;
        b_p1_d    = load_p1 ? in_b    : b_p1_q;
        op_p1_d   = load_p1 ? in_op   : op_p1_q;
        mask_p1_d = load_p1 ? in_mask : mask_p1_q;
    end

    // Stage 2: lane results and flags
    always_comb begin
        vld_p2_d   = adv_p2 ? vld_p1_q : vld_p2_q;
        data_p2_d  = data_p2_q;
        zero_p2_d  = zero_p2_q;
        neg_p2_d   = neg_p2_q;
        carry_p2_d = carry_p2_q;
        err_p2_d   = err_p2_q;
        lr         = '0;
        if (load_p2) begin
            err_p2_d = (op_p1_q > OP_ROL);
            for (int i = 0; i < LANES; i++) begin
                lr = lane_op(a_p1_q[i*WIDTH +: WIDTH], b_p1_q[i*WIDTH +: WIDTH],
                             op_p1_q, mask_p1_q[i]);
                data_p2_d[i*WIDTH +: WIDTH] = lr.res;
                zero_p2_d[i]  = lr.z;
                neg_p2_d[i]   = lr.n;
                carry_p2_d[i] = lr.c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            data_p2_q  <= '0;
            zero_p2_q  <= '0;
            neg_p2_q   <= '0;
            carry_p2_q <= '0;
            err_p2_q   <= 1'b0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            data_p2_q  <= data_p2_d;
            zero_p2_q  <= zero_p2_d;
            neg_p2_q   <= neg_p2_d;
            carry_p2_q <= carry_p2_d;
            err_p2_q   <= err_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        a_p1_q    <= a_p1_d;
        b_p1_q    <= b_p1_d;
        op_p1_q   <= op_p1_d;
        mask_p1_q <= mask_p1_d;
    end

    assign out_valid = vld_p2_q;
    assign out_data  = data_p2_q;
    assign out_zero  = zero_p2_q;
    assign out_neg   = neg_p2_q;
    assign out_carry = carry_p2_q;
    assign out_err   = err_p2_q;

endmodule
